// File: rtl/mvau_defn.sv
// Shared definitions for the MVAU input-buffer controller: FSM state type and
// a counter-width helper that stays at least one bit wide.
package mvau_defn;

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } buf_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvau_fold_cnt.sv
// Wrap-around fold counter: counts 0..MODULUS-1 on enable, flags the terminal
// count, and clears on synchronous active-low reset.
module mvau_fold_cnt #(
  parameter int MODULUS = 4,
  parameter int W       = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop sees pre-edge values.
    if (!rst_n)   cnt <= '0;
    else if (en)  cnt <= tc ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/mvau_inp_buf_ctrl.sv
// MVAU input activation buffer controller: writes the first neuron fold through
// to compute, replays it NF-1 times. Optional stall counter: MVAU_BUF_STALL_CNT_EN.
module mvau_inp_buf_ctrl
  import mvau_defn::*;
#(
  parameter  int MatrixW  = 20,
  parameter  int MatrixH  = 20,
  parameter  int SIMD     = 2,
  parameter  int PE       = 2,
  localparam int SF       = MatrixW / SIMD,
  localparam int NF       = MatrixH / PE,
  localparam int BUF_ADDR = $clog2(SF),
  localparam int NF_W     = cnt_width(NF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_v,
  output logic                in_rdy,
  input  logic                out_rdy,
  output logic                out_v,
  output logic                buf_wr_en,
  output logic                buf_rd_en,
  output logic [BUF_ADDR-1:0] buf_addr,
  output logic                sf_last,
  output logic                nf_last
`ifdef MVAU_BUF_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  buf_state_e          state;
  logic [BUF_ADDR-1:0] sf_cnt;
  logic [NF_W-1:0]     nf_cnt;
  logic                sf_tc;
  logic                nf_tc;
  logic                in_fill;
  logic                xfer;

  assign in_fill = (state == FILL);
  // In REPLAY the word comes from the buffer, so only the consumer gates a beat.
  assign xfer    = rst_n & out_rdy & (in_fill ? in_v : 1'b1);

  mvau_fold_cnt #(.MODULUS(SF), .W(BUF_ADDR)) u_sf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (xfer),
    .cnt   (sf_cnt),
    .tc    (sf_tc)
  );

  mvau_fold_cnt #(.MODULUS(NF), .W(NF_W)) u_nf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (xfer & sf_tc),
    .cnt   (nf_cnt),
    .tc    (nf_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
    end else if (xfer && sf_tc) begin
      case (state)
        FILL:    if (NF > 1) state <= REPLAY;
        REPLAY:  if (nf_tc)  state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    in_rdy    = 1'b0;
    out_v     = 1'b0;
    buf_wr_en = 1'b0;
    buf_rd_en = 1'b0;
    buf_addr  = '0;
    sf_last   = 1'b0;
    nf_last   = 1'b0;
    if (rst_n) begin
      buf_addr = sf_cnt;
      sf_last  = sf_tc;
      nf_last  = (nf_cnt == NF_W'(NF - 1));
      if (in_fill) begin
        in_rdy    = out_rdy;
        out_v     = in_v;
        buf_wr_en = in_v & out_rdy;
      end else begin
        out_v     = 1'b1;
        buf_rd_en = 1'b1;
      end
    end
  end

`ifdef MVAU_BUF_STALL_CNT_EN
  logic stall;

  // Backpressure cycles plus FILL cycles where compute waits on upstream.
  assign stall = (out_v & ~out_rdy) | (in_fill & ~in_v & out_rdy);

  always_ff @(posedge clk) begin
    if (!rst_n)                         stall_cnt <= '0;
    else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + 32'd1;
  end
`else
  // Stall instrumentation is not built in this configuration.
`endif

endmodule

// File: tb/tb_mvau_inp_buf_ctrl.sv
// Self-checking bench: an NF=3 and an NF=1 instance share stimulus and are
// compared every cycle against a beat-index reference model.
module tb_mvau_inp_buf_ctrl;

  localparam int SF = 4;
  localparam int NF_CFG [2] = '{3, 1};

  logic clk = 1'b0;
  logic rst_n;
  logic in_v;
  logic out_rdy;

  logic       in_rdy_w [2];
  logic       out_v_w  [2];
  logic       wr_w     [2];
  logic       rd_w     [2];
  logic       sfl_w    [2];
  logic       nfl_w    [2];
  logic [1:0] addr_w   [2];
`ifdef MVAU_BUF_STALL_CNT_EN
  logic [31:0] stall_a;
  logic [31:0] stall_b;
  logic [31:0] stall_exp;
`endif

  int checks = 0;
  int errors = 0;
  int beat [2];

  always #5 clk = ~clk;

  mvau_inp_buf_ctrl #(.MatrixW(8), .MatrixH(6), .SIMD(2), .PE(2)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_v      (in_v),
    .in_rdy    (in_rdy_w[0]),
    .out_rdy   (out_rdy),
    .out_v     (out_v_w[0]),
    .buf_wr_en (wr_w[0]),
    .buf_rd_en (rd_w[0]),
    .buf_addr  (addr_w[0]),
    .sf_last   (sfl_w[0]),
    .nf_last   (nfl_w[0])
`ifdef MVAU_BUF_STALL_CNT_EN
    ,
    .stall_cnt (stall_a)
`endif
  );

  mvau_inp_buf_ctrl #(.MatrixW(8), .MatrixH(2), .SIMD(2), .PE(2)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_v      (in_v),
    .in_rdy    (in_rdy_w[1]),
    .out_rdy   (out_rdy),
    .out_v     (out_v_w[1]),
    .buf_wr_en (wr_w[1]),
    .buf_rd_en (rd_w[1]),
    .buf_addr  (addr_w[1]),
    .sf_last   (sfl_w[1]),
    .nf_last   (nfl_w[1])
`ifdef MVAU_BUF_STALL_CNT_EN
    ,
    .stall_cnt (stall_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare the
  // combinational outputs, then advance the model to the next rising edge.
  task automatic step(input logic r, input logic iv, input logic ordy);
    @(negedge clk);
    rst_n   = r;
    in_v    = iv;
    out_rdy = ordy;
    #1;
`ifdef MVAU_BUF_STALL_CNT_EN
    check("stall_cnt", stall_a, stall_exp);
`endif
    for (int d = 0; d < 2; d++) begin
      bit   rep;
      int   a;
      int   nf;
      logic e_ov;
      rep  = (beat[d] >= SF);
      a    = beat[d] % SF;
      nf   = beat[d] / SF;
      e_ov = r & (rep | iv);
      check($sformatf("d%0d in_rdy", d),    32'(in_rdy_w[d]), 32'(r & !rep & ordy));
      check($sformatf("d%0d out_v", d),     32'(out_v_w[d]),  32'(e_ov));
      check($sformatf("d%0d buf_wr_en", d), 32'(wr_w[d]),     32'(r & !rep & iv & ordy));
      check($sformatf("d%0d buf_rd_en", d), 32'(rd_w[d]),     32'(r & rep));
      check($sformatf("d%0d buf_addr", d),  32'(addr_w[d]),   r ? 32'(a) : 32'd0);
      check($sformatf("d%0d sf_last", d),   32'(sfl_w[d]),    32'(r & (a == SF - 1)));
      check($sformatf("d%0d nf_last", d),   32'(nfl_w[d]),    32'(r & (nf == NF_CFG[d] - 1)));
`ifdef MVAU_BUF_STALL_CNT_EN
      if (d == 0) begin
        if (!r) stall_exp = 32'd0;
        else if (((e_ov & !ordy) | (!rep & !iv & ordy)) && stall_exp != 32'hFFFF_FFFF)
          stall_exp = stall_exp + 32'd1;
      end
`endif
      if (!r)               beat[d] = 0;
      else if (e_ov & ordy) beat[d] = (beat[d] + 1) % (SF * NF_CFG[d]);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    in_v    = 1'b0;
    out_rdy = 1'b0;
    beat    = '{0, 0};
`ifdef MVAU_BUF_STALL_CNT_EN
    stall_exp = 32'd0;
`endif

    // Reset: all outputs forced low regardless of handshake inputs.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Continuous stream, two full vectors (24 output beats on the NF=3 unit).
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 1'b1);

    // Backpressure mid-REPLAY at addr 2 for three cycles, then finish vector.
    for (int i = 0; i < 6; i++)  step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)  step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)  step(1'b1, 1'b1, 1'b1);

    // Input bubbles in FILL, then drain the vector.
    for (int i = 0; i < 4; i++)  step(1'b1, (i % 2 == 0), 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1);

    // Reset mid-REPLAY at nf fold 1, sf fold 2; next cycle restarts at addr 0.
    for (int i = 0; i < 6; i++)  step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);

    // Stall accounting: 5 backpressure cycles in REPLAY plus 2 idle FILL cycles.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)  step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)  step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)  step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++)  step(1'b1, 1'b0, 1'b1);
`ifdef MVAU_BUF_STALL_CNT_EN
    @(negedge clk);
    #1;
    check("stall_cnt_total", stall_a, 32'd7);
`endif

    // Randomised handshakes with occasional mid-stream resets.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(63) != 0), 1'($urandom), ($urandom_range(3) != 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
